// File: rtl/operand_bank_pingpong.sv
// -----------------------------------------------------------------------------
// operand_bank_pingpong
//
// Double-buffered operand storage for the matrix engine. Every operand matrix
// has two banks: the host fills the "load" bank through a byte-strobed write
// port (with registered read-back) while the engine streams the "active"
// bank. A commit swaps the banks, either at once (IDLE) or deferred to the
// last-beat transfer of a running stream.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   wr_*_i               host write into the load bank (byte strobes)
//   rd_*_i / rd_*_o      host read of the load bank, 1-cycle latency
//   commit_i             bank swap request; commit_done_o pulses on the swap
//   start_i              start streaming the active bank
//   stream_*             valid/ready beat stream, all operands side by side
//   busy_o               high while a stream is in progress
// -----------------------------------------------------------------------------
module operand_bank_pingpong #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int NUM_OPS    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int OP_WIDTH   = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          wr_en_i,
  input  logic [OP_WIDTH-1:0]           wr_op_i,
  input  logic [ADDR_WIDTH-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic [DATA_WIDTH/8-1:0]       wr_strb_i,
  input  logic                          rd_en_i,
  input  logic [OP_WIDTH-1:0]           rd_op_i,
  input  logic [ADDR_WIDTH-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic                          rd_valid_o,
  input  logic                          commit_i,
  output logic                          commit_done_o,
  input  logic                          start_i,
  output logic                          stream_valid_o,
  input  logic                          stream_ready_i,
  output logic [NUM_OPS*DATA_WIDTH-1:0] stream_data_o,
  output logic [ADDR_WIDTH-1:0]         stream_idx_o,
  output logic                          stream_last_o,
  output logic                          busy_o
);

  localparam int                    NUM_LANES = DATA_WIDTH / 8;
  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable in range checks.
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [OP_WIDTH:0]     NUM_OPS_L = (OP_WIDTH + 1)'(NUM_OPS);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    bank_sel_q, bank_sel_d;
  logic                    pending_q, pending_d;
  logic                    commit_done_q, commit_done_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q;

  // Storage: [bank][operand][word]
  logic [DATA_WIDTH-1:0]   mem_q [2][NUM_OPS][DEPTH];

  logic                    load_bank_s;
  logic                    wr_hit_s;
  logic                    rd_hit_s;
  logic                    streaming_s;
  logic                    xfer_s;
  logic                    last_xfer_s;
  logic [NUM_OPS*DATA_WIDTH-1:0] stream_data_s;

  assign load_bank_s = ~bank_sel_q;
  assign wr_hit_s    = wr_en_i && ({1'b0, wr_op_i} < NUM_OPS_L) && ({1'b0, wr_addr_i} < DEPTH_L);
  assign rd_hit_s    = ({1'b0, rd_op_i} < NUM_OPS_L) && ({1'b0, rd_addr_i} < DEPTH_L);
  assign streaming_s = (state_q == ST_STREAM);
  // valid is purely a function of state, so ready never reaches it combinationally.
  assign xfer_s      = streaming_s && stream_ready_i;
  assign last_xfer_s = xfer_s && (idx_q == LAST_IDX);

  // Storage array: cleared on reset, byte-strobed host writes into the load bank.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < 2; b++) begin
        for (int o = 0; o < NUM_OPS; o++) begin
          for (int a = 0; a < DEPTH; a++) begin
            mem_q[b][o][a] <= '0;
          end
        end
      end
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (wr_hit_s && wr_strb_i[k]) begin
          mem_q[load_bank_s][wr_op_i][wr_addr_i][8*k +: 8] <= wr_data_i[8*k +: 8];
        end
      end
    end
  end

  // Read-back mux: load-bank word, zero when out of range, hold when idle.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      if (rd_hit_s) begin
        rd_data_d = mem_q[load_bank_s][rd_op_i][rd_addr_i];
      end else begin
        rd_data_d = '0;
      end
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Control FSM next state: stream sequencing and commit/swap handling.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    bank_sel_d    = bank_sel_q;
    pending_d     = pending_q;
    commit_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pending_d = 1'b0;
        // Swap first so a same-edge start streams the freshly committed bank.
        if (commit_i) begin
          bank_sel_d    = ~bank_sel_q;
          commit_done_d = 1'b1;
        end else begin
          bank_sel_d    = bank_sel_q;
        end
        if (start_i) begin
          state_d = ST_STREAM;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (last_xfer_s) begin
          state_d   = ST_IDLE;
          idx_d     = '0;
          pending_d = 1'b0;
          // A commit arriving on the last-beat edge is folded into this swap.
          if (pending_q || commit_i) begin
            bank_sel_d    = ~bank_sel_q;
            commit_done_d = 1'b1;
          end else begin
            bank_sel_d    = bank_sel_q;
          end
        end else if (xfer_s) begin
          idx_d     = idx_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          pending_d = pending_q || commit_i;
        end else begin
          pending_d = pending_q || commit_i;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        idx_d     = '0;
        pending_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      bank_sel_q    <= 1'b0;
      pending_q     <= 1'b0;
      commit_done_q <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      bank_sel_q    <= bank_sel_d;
      pending_q     <= pending_d;
      commit_done_q <= commit_done_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_en_i;
    end
  end

  // Stream data: active-bank word at the current index, zero outside a stream.
  always_comb begin
    stream_data_s = '0;
    for (int o = 0; o < NUM_OPS; o++) begin
      if (streaming_s) begin
        stream_data_s[o*DATA_WIDTH +: DATA_WIDTH] = mem_q[bank_sel_q][o][idx_q];
      end else begin
        stream_data_s[o*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  assign rd_data_o      = rd_data_q;
  assign rd_valid_o     = rd_valid_q;
  assign commit_done_o  = commit_done_q;
  assign stream_valid_o = streaming_s;
  assign stream_idx_o   = idx_q;
  assign stream_last_o  = streaming_s && (idx_q == LAST_IDX);
  assign stream_data_o  = stream_data_s;
  assign busy_o         = streaming_s;

endmodule

// File: tb/tb_operand_bank_pingpong.sv
// Self-checking bench for operand_bank_pingpong. Expected read data and stream
// beats come from a bench-side two-bank model and are queued when stimulus is
// driven, then popped when the DUT presents them. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_operand_bank_pingpong;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int NOPS  = 2;
  localparam int AW    = 4;
  localparam int OW    = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               wr_en;
  logic [OW-1:0]      wr_op;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [DW/8-1:0]    wr_strb;
  logic               rd_en;
  logic [OW-1:0]      rd_op;
  logic [AW-1:0]      rd_addr;
  logic [DW-1:0]      rd_data;
  logic               rd_valid;
  logic               commit;
  logic               commit_done;
  logic               start;
  logic               stream_valid;
  logic               stream_ready;
  logic [NOPS*DW-1:0] stream_data;
  logic [AW-1:0]      stream_idx;
  logic               stream_last;
  logic               busy;

  operand_bank_pingpong dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_en_i(wr_en), .wr_op_i(wr_op), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_strb_i(wr_strb),
    .rd_en_i(rd_en), .rd_op_i(rd_op), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .commit_i(commit), .commit_done_o(commit_done),
    .start_i(start), .stream_valid_o(stream_valid), .stream_ready_i(stream_ready),
    .stream_data_o(stream_data), .stream_idx_o(stream_idx), .stream_last_o(stream_last),
    .busy_o(busy)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]      model [2][NOPS][DEPTH];
  logic               model_sel;
  logic [DW-1:0]      rd_q [$];
  logic [NOPS*DW-1:0] st_q [$];

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int o = 0; o < NOPS; o++)
        for (int a = 0; a < DEPTH; a++)
          model[b][o][a] = 32'h0;
    model_sel = 1'b0;
  endtask

  // Queue every beat of the currently active bank in the model.
  task automatic push_stream();
    st_q.delete();
    for (int i = 0; i < DEPTH; i++)
      st_q.push_back({model[model_sel][1][i], model[model_sel][0][i]});
  endtask

  // Drives one write for one edge and mirrors it into the model.
  task automatic do_write(input logic [OW-1:0] op, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [3:0] s);
    logic lb;
    lb = ~model_sel;
    wr_en = 1'b1; wr_op = op; wr_addr = a; wr_data = d; wr_strb = s;
    for (int k = 0; k < 4; k++)
      if (s[k]) model[lb][op][a][8*k +: 8] = d[8*k +: 8];
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Drives one read request for one edge and queues the expected data.
  task automatic do_read(input logic [OW-1:0] op, input logic [AW-1:0] a);
    logic lb;
    lb = ~model_sel;
    rd_en = 1'b1; rd_op = op; rd_addr = a;
    rd_q.push_back(model[lb][op][a]);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (rd_data !== 32'h0 || rd_valid !== 1'b0 || commit_done !== 1'b0)
      begin errors++; $display("FAIL reset_rd got d=%h v=%b cd=%b want 0", rd_data, rd_valid, commit_done); end
    checks++;
    if (stream_valid !== 1'b0 || stream_idx !== 4'h0 || stream_last !== 1'b0 || busy !== 1'b0 || stream_data !== 64'h0)
      begin errors++; $display("FAIL reset_stream got v=%b i=%h l=%b b=%b d=%h want 0", stream_valid, stream_idx, stream_last, busy, stream_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < DEPTH; a++) begin
      do_read(1'b0, a[AW-1:0]);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== rd_q[0])
        begin errors++; $display("FAIL reset_read a=%0d got v=%b d=%h want v=1 d=%h", a, rd_valid, rd_data, rd_q[0]); end
      void'(rd_q.pop_front());
    end
  endtask

  task automatic test_rw();
    do_write(1'b0, 4'd0, 32'd8, 4'hF);
    do_write(1'b0, 4'd2, 32'd88, 4'hF);
    do_read(1'b0, 4'd0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== rd_q[0] || rd_data !== 32'd8)
      begin errors++; $display("FAIL rw_a0 got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, 32'd8); end
    void'(rd_q.pop_front());
    do_read(1'b0, 4'd2);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== rd_q[0] || rd_data !== 32'h58)
      begin errors++; $display("FAIL rw_a2 got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, 32'h58); end
    void'(rd_q.pop_front());
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h58)
      begin errors++; $display("FAIL rw_hold got v=%b d=%h want v=0 d=00000058", rd_valid, rd_data); end
    // Read and write of the same word on one edge returns the old data.
    rd_en = 1'b1; rd_op = 1'b0; rd_addr = 4'd2;
    rd_q.push_back(model[~model_sel][0][2]);
    do_write(1'b0, 4'd2, 32'h77, 4'hF);
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== rd_q[0])
      begin errors++; $display("FAIL rw_rbw got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, rd_q[0]); end
    void'(rd_q.pop_front());
  endtask

  task automatic test_strobe();
    do_write(1'b1, 4'd5, 32'hAABBCCDD, 4'hF);
    do_write(1'b1, 4'd5, 32'h11223344, 4'h5);
    do_read(1'b1, 4'd5);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== rd_q[0] || rd_data !== 32'hAA22CC44)
      begin errors++; $display("FAIL strobe_mix got v=%b d=%h want v=1 d=aa22cc44", rd_valid, rd_data); end
    void'(rd_q.pop_front());
    do_write(1'b1, 4'd15, 32'h12345678, 4'hF);
    do_write(1'b1, 4'd15, 32'hFFFFFFFF, 4'h0);
    do_read(1'b1, 4'd15);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== rd_q[0] || rd_data !== 32'h12345678)
      begin errors++; $display("FAIL strobe_none got v=%b d=%h want v=1 d=12345678", rd_valid, rd_data); end
    void'(rd_q.pop_front());
  endtask

  task automatic test_stream();
    for (int i = 0; i < DEPTH; i++) begin
      do_write(1'b0, i[AW-1:0], i, 4'hF);
      do_write(1'b1, i[AW-1:0], 32'h100 + i, 4'hF);
    end
    commit = 1'b1;
    model_sel = ~model_sel;
    @(negedge clk);
    commit = 1'b0;
    checks++;
    if (commit_done !== 1'b1) begin errors++; $display("FAIL stream_commit got %b want 1", commit_done); end
    @(negedge clk);
    checks++;
    if (commit_done !== 1'b0) begin errors++; $display("FAIL stream_commit_pulse got %b want 0", commit_done); end
    push_stream();
    start = 1'b1; stream_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (stream_valid !== 1'b1 || stream_idx !== i[AW-1:0] || stream_data !== st_q[0] ||
          stream_data !== {32'h100 + i, i} || stream_last !== (i == DEPTH - 1) || busy !== 1'b1)
        begin errors++; $display("FAIL stream_beat%0d got v=%b i=%0d d=%h l=%b want v=1 i=%0d d=%h l=%b",
          i, stream_valid, stream_idx, stream_data, stream_last, i, st_q[0], (i == DEPTH - 1)); end
      void'(st_q.pop_front());
      @(negedge clk);
    end
    stream_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || stream_valid !== 1'b0 || stream_idx !== 4'h0)
      begin errors++; $display("FAIL stream_end got b=%b v=%b i=%0d want 0", busy, stream_valid, stream_idx); end
  endtask

  task automatic test_backpressure();
    int n, c;
    logic exp_done;
    logic lb;
    push_stream();
    start = 1'b1; stream_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 0; c = 0; exp_done = 1'b0;
    while (n < DEPTH && c < 200) begin
      checks++;
      if (commit_done !== exp_done)
        begin errors++; $display("FAIL bp_done c=%0d got %b want %b", c, commit_done, exp_done); end
      checks++;
      if (stream_valid !== 1'b1 || stream_idx !== n[AW-1:0] || stream_data !== st_q[0])
        begin errors++; $display("FAIL bp_beat c=%0d got v=%b i=%0d d=%h want v=1 i=%0d d=%h",
          c, stream_valid, stream_idx, stream_data, n, st_q[0]); end
      wr_en = 1'b0; commit = 1'b0;
      if (c == 1) begin
        lb = ~model_sel;
        wr_en = 1'b1; wr_op = 1'b0; wr_addr = 4'd0; wr_data = 32'hDEAD; wr_strb = 4'hF;
        model[lb][0][0] = 32'hDEAD;
      end
      // Commit at beat 4 and again at beat 8: the second merges into the first.
      if ((n == 4 || n == 8) && (c % 3 == 0)) commit = 1'b1;
      stream_ready = (c % 3 == 2);
      exp_done = 1'b0;
      if (stream_ready) begin
        if (n == DEPTH - 1) begin
          exp_done = 1'b1;
          model_sel = ~model_sel;
        end
        void'(st_q.pop_front());
        n++;
      end
      c++;
      @(negedge clk);
    end
    wr_en = 1'b0; commit = 1'b0; stream_ready = 1'b0;
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL bp_count got %0d want %0d", n, DEPTH); end
    checks++;
    if (commit_done !== 1'b1 || stream_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL bp_end got cd=%b v=%b b=%b want cd=1 v=0 b=0", commit_done, stream_valid, busy); end
    // Second stream shows the committed bank with the new word 0.
    push_stream();
    start = 1'b1; stream_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (stream_valid !== 1'b1 || stream_data !== st_q[0] || (i == 0 && stream_data[31:0] !== 32'hDEAD) || commit_done !== 1'b0)
        begin errors++; $display("FAIL bp_second beat%0d got v=%b d=%h cd=%b want v=1 d=%h cd=0",
          i, stream_valid, stream_data, commit_done, st_q[0]); end
      void'(st_q.pop_front());
      @(negedge clk);
    end
    stream_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_write(1'b1, 4'd3, 32'hBEEF, 4'hF);
    commit = 1'b1; start = 1'b1; stream_ready = 1'b1;
    model_sel = ~model_sel;
    push_stream();
    @(negedge clk);
    commit = 1'b0; start = 1'b0;
    checks++;
    if (commit_done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", commit_done); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (stream_valid !== 1'b1 || stream_data !== st_q[0] || (i == 3 && stream_data[63:32] !== 32'hBEEF))
        begin errors++; $display("FAIL b2b_beat%0d got v=%b d=%h want v=1 d=%h", i, stream_valid, stream_data, st_q[0]); end
      void'(st_q.pop_front());
      @(negedge clk);
    end
    stream_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    push_stream();
    start = 1'b1; stream_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    checks++;
    if (stream_valid !== 1'b1 || stream_idx !== 4'd6)
      begin errors++; $display("FAIL arst_pre got v=%b i=%0d want v=1 i=6", stream_valid, stream_idx); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (stream_valid !== 1'b0 || busy !== 1'b0 || stream_idx !== 4'h0)
      begin errors++; $display("FAIL arst_drop got v=%b b=%b i=%0d want 0", stream_valid, busy, stream_idx); end
    stream_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    do_read(1'b1, 4'd5);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== rd_q[0] || rd_data !== 32'h0)
      begin errors++; $display("FAIL arst_read got v=%b d=%h want v=1 d=0", rd_valid, rd_data); end
    void'(rd_q.pop_front());
    push_stream();
    start = 1'b1; stream_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (stream_valid !== 1'b1 || stream_idx !== i[AW-1:0] || stream_data !== st_q[0] || stream_data !== 64'h0)
        begin errors++; $display("FAIL arst_beat%0d got v=%b i=%0d d=%h want v=1 d=0", i, stream_valid, stream_idx, stream_data); end
      void'(st_q.pop_front());
      @(negedge clk);
    end
    stream_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_op = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rd_en = 1'b0; rd_op = '0; rd_addr = '0; commit = 1'b0; start = 1'b0; stream_ready = 1'b0;
    model_clear();
    test_reset();
    test_rw();
    test_strobe();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
